mpsoc_mpi_noc_arb: RTL and testbench

Packet-level round-robin arbiter that shares one NoC output link between several MPI endpoints, such as the AHB and WishBone MPI bridges of a tile. Each endpoint presents a flit stream with valid/ready. The arbiter grants the link to one endpoint for a whole packet, header through last flit, so packets from different endpoints never interleave on the link. It sits between the endpoints' noc_out ports and the router's local input port.

---
 rtl/mpsoc_mpi_pkg.sv | 21 ++
 rtl/mpsoc_mpi_rr_arb.sv | 33 +++
 rtl/mpsoc_mpi_noc_arb.sv | 104 ++++++++++
 tb/tb_mpsoc_mpi_noc_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpsoc_mpi_pkg.sv
// Shared MPI flit encoding and arbiter FSM states.
package mpsoc_mpi_pkg;

    localparam int unsigned FLIT_TYPE_W = 2;

    localparam logic [FLIT_TYPE_W-1:0] PAYLOAD = 2'b00;
    localparam logic [FLIT_TYPE_W-1:0] HEADER  = 2'b01;
    localparam logic [FLIT_TYPE_W-1:0] LAST    = 2'b10;
    localparam logic [FLIT_TYPE_W-1:0] SINGLE  = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // A flit of this type closes the packet currently holding the link.
    function automatic logic flit_is_tail(input logic [FLIT_TYPE_W-1:0] ftype);
        return (ftype == LAST) || (ftype == SINGLE);
    endfunction

endpackage

// File: rtl/mpsoc_mpi_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, circularly.
module mpsoc_mpi_rr_arb #(
    parameter int unsigned INPUTS    = 2,
    parameter int unsigned IDX_WIDTH = $clog2(INPUTS)
) (
    input  logic [INPUTS-1:0]    req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int N = int'(INPUTS);

    logic [2*INPUTS-1:0] req2;

    assign req2 = {req, req};

    // Scan the doubled vector downward from ptr+N-1 so the lowest offset wins.
    always_comb begin
        int pos;
        pos     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (req2[pos]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_WIDTH'(pos % N);
            end
        end
    end

endmodule

// File: rtl/mpsoc_mpi_noc_arb.sv
// Packet-level round-robin arbiter sharing one NoC link among MPI endpoints.
module mpsoc_mpi_noc_arb
    import mpsoc_mpi_pkg::*;
#(
    parameter int unsigned NoC_DATA_WIDTH = 32,
    parameter int unsigned NoC_TYPE_WIDTH = 2,
    parameter int unsigned NoC_FLIT_WIDTH = NoC_DATA_WIDTH + NoC_TYPE_WIDTH,
    parameter int unsigned INPUTS         = 2,
    parameter int unsigned IDX_WIDTH      = $clog2(INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [INPUTS*NoC_FLIT_WIDTH-1:0] in_flit,
    input  logic [INPUTS-1:0]                in_valid,
    output logic [INPUTS-1:0]                in_ready,
    output logic [NoC_FLIT_WIDTH-1:0]        out_flit,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [INPUTS-1:0]                grant
);

    arb_state_t state, state_next;
    logic [IDX_WIDTH-1:0] owner, owner_next;
    logic [IDX_WIDTH-1:0] rr_ptr, rr_ptr_next;

    logic [IDX_WIDTH-1:0]      pick_idx;
    logic                      pick_any;
    logic [NoC_FLIT_WIDTH-1:0] own_flit;
    logic                      own_valid;
    logic [INPUTS-1:0]         own_onehot;
    logic [NoC_TYPE_WIDTH-1:0] own_type;

    mpsoc_mpi_rr_arb #(
        .INPUTS    (INPUTS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Select the current owner's stream without variable part-selects.
    always_comb begin
        own_flit   = '0;
        own_valid  = 1'b0;
        own_onehot = '0;
        for (int i = 0; i < int'(INPUTS); i++) begin
            if (owner == IDX_WIDTH'(i)) begin
                own_flit      = in_flit[i*NoC_FLIT_WIDTH +: NoC_FLIT_WIDTH];
                own_valid     = in_valid[i];
                own_onehot[i] = 1'b1;
            end
        end
    end

    assign own_type = own_flit[NoC_FLIT_WIDTH-1 -: NoC_TYPE_WIDTH];

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    // Arbitrate in IDLE; in LOCKED pass the owner's stream through until its tail flit.
    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        out_flit    = '0;
        out_valid   = 1'b0;
        in_ready    = '0;
        grant       = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    owner_next = pick_idx;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                grant     = own_onehot;
                out_flit  = own_flit;
                out_valid = own_valid;
                in_ready  = own_onehot & {INPUTS{out_ready}};
                if (own_valid && out_ready &&
                    flit_is_tail(FLIT_TYPE_W'(own_type))) begin
                    state_next  = IDLE;
                    rr_ptr_next = (owner == IDX_WIDTH'(INPUTS - 1)) ?
                                  '0 : owner + IDX_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mpsoc_mpi_noc_arb.sv
// Randomized scoreboard bench for the packet round-robin NoC arbiter.
module tb_mpsoc_mpi_noc_arb;
    import mpsoc_mpi_pkg::*;

    localparam int NI = 2;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int FW = DW + TW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI*FW-1:0]  in_flit;
    logic [NI-1:0]     in_valid;
    logic [NI-1:0]     in_ready;
    logic [FW-1:0]     out_flit;
    logic              out_valid;
    logic              out_ready;
    logic [NI-1:0]     grant;

    mpsoc_mpi_noc_arb #(
        .NoC_DATA_WIDTH (DW),
        .NoC_TYPE_WIDTH (TW),
        .NoC_FLIT_WIDTH (FW),
        .INPUTS         (NI),
        .IDX_WIDTH      ($clog2(NI))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] flit;
        int            owner;
    } exp_t;

    int total = 0;
    int bad   = 0;

    logic [FW-1:0] src_q [NI][$];
    int            len_q [NI][$];
    exp_t          exp_q [$];
    bit   [NI-1:0] acc;

    // Reference model of the link owner, kept at packet granularity.
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_rem;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, req);
        end
    endtask

    // Monitor: every accepted output flit must be the next expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_flit at %0t: got=%0h expected=none", $time, out_flit);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_flit", 64'(out_flit), 64'(e.flit));
                chk("xfer_grant", 64'(grant), 64'(1) << e.owner);
            end
        end
    end

    // Build npk packets for endpoint ep; first flit of a multi-flit packet is
    // occasionally PAYLOAD and middles occasionally HEADER (neither ends a packet).
    task automatic gen(input int ep, input int npk);
        for (int p = 0; p < npk; p++) begin
            int len;
            len = $urandom_range(1, 4);
            len_q[ep].push_back(len);
            for (int f = 0; f < len; f++) begin
                logic [TW-1:0] t;
                logic [DW-1:0] d;
                if (len == 1)
                    t = ($urandom_range(0, 3) == 0) ? LAST : SINGLE;
                else if (f == 0)
                    t = ($urandom_range(0, 4) == 0) ? PAYLOAD : HEADER;
                else if (f == len - 1)
                    t = LAST;
                else
                    t = ($urandom_range(0, 3) == 0) ? HEADER : PAYLOAD;
                d = {8'(ep), 8'(p), 8'(f), 8'($urandom)};
                src_q[ep].push_back({t, d});
            end
        end
    endtask

    // Hold reset with all endpoints requesting and check the link stays quiet.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '1;
        in_flit   = {NI*FW{1'b1}};
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", 64'(out_valid), 64'(0));
            chk("rst_grant", 64'(grant), 64'(0));
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            chk("rst_out_flit", 64'(out_flit), 64'(0));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            src_q[i].delete();
            len_q[i].delete();
        end
        exp_q.delete();
        acc      = '0;
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_rem    = 0;
        rst      = 1'b0;
        in_valid = '0;
    endtask

    // One clock: retire accepted flits, drive new inputs, then check control outputs.
    task automatic step(input int vp, input int rp);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        for (int i = 0; i < NI; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(0, 99) < vp) begin
                in_valid[i]           = 1'b1;
                in_flit[i*FW +: FW]   = src_q[i][0];
            end else begin
                in_valid[i]           = 1'b0;
                in_flit[i*FW +: FW]   = {2'($urandom), 32'($urandom)};
            end
        end
        out_ready = ($urandom_range(0, 99) < rp);
        @(negedge clk);
        for (int i = 0; i < NI; i++) acc[i] = in_valid[i] && in_ready[i];
        if (!m_locked) begin
            chk("idle_out_valid", 64'(out_valid), 64'(0));
            chk("idle_grant", 64'(grant), 64'(0));
            chk("idle_in_ready", 64'(in_ready), 64'(0));
            chk("idle_out_flit", 64'(out_flit), 64'(0));
            for (int k = 0; k < NI; k++) begin
                int j;
                j = (m_ptr + k) % NI;
                if (!m_locked && in_valid[j]) begin
                    int len;
                    m_locked = 1'b1;
                    m_owner  = j;
                    len      = len_q[j].pop_front();
                    m_rem    = len;
                    for (int f = 0; f < len; f++) begin
                        exp_t e;
                        e.flit  = src_q[j][f];
                        e.owner = j;
                        exp_q.push_back(e);
                    end
                end
            end
        end else begin
            chk("lock_grant", 64'(grant), 64'(1) << m_owner);
            chk("lock_in_ready", 64'(in_ready), out_ready ? (64'(1) << m_owner) : 64'(0));
            chk("lock_out_valid", 64'(out_valid), 64'(in_valid[m_owner]));
            if (in_valid[m_owner] && out_ready) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % NI;
                end
            end
        end
    endtask

    function automatic bit drained();
        bit e;
        e = !m_locked && (exp_q.size() == 0);
        for (int i = 0; i < NI; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic run_phase(input int vp, input int rp, input int npk);
        bit done;
        done = 1'b0;
        for (int i = 0; i < NI; i++) gen(i, npk);
        for (int c = 0; c < 4000 && !done; c++) begin
            step(vp, rp);
            done = drained();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: got=pending expected=drained");
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '1;
        in_flit   = '0;
        out_ready = 1'b1;
        acc       = '0;

        do_reset();
        run_phase(100, 100, 8);
        run_phase(70, 60, 20);
        run_phase(50, 30, 20);

        // Abandon traffic mid-packet, then confirm arbitration restarts cleanly.
        for (int i = 0; i < NI; i++) gen(i, 20);
        for (int c = 0; c < 25; c++) step(90, 90);
        for (int c = 0; c < 200 && !m_locked; c++) step(90, 90);
        total++;
        if (!m_locked) begin
            bad++;
            $display("FAIL abort_lock: got=idle expected=locked");
        end
        do_reset();
        run_phase(80, 80, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
